// File: rtl/cpu_bus_initiator.sv
// cpu_bus_initiator
// Accepts one load/store request at a time from the load-store stage. It turns
// each request into a single transaction on the memory-mapped CPU bus and waits
// for the responder to complete. The finished request is reported back with a
// one-cycle response pulse that carries the extended load data or an error.
//
// Ports
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   req_valid/req_ready request handshake; accepted when both are high
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata byte address and right-aligned store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load result (0 for stores and errors)
//   resp_err            misaligned, illegal size or bus timeout
//   bus_address/wdata   held bus fields for the whole transaction
//   bus_wlen            00 RD32, 01 WR8, 10 WR16, 11 WR32
//   bus_en_n            active-low one-cycle start strobe
//   bus_ready/bus_rdata responder completion handshake and read data

module cpu_bus_initiator #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] bus_address,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_wlen,
  output logic        bus_en_n,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP} state_t;

  state_t        state;
  logic          lat_we;
  logic [1:0]    lat_size;
  logic          lat_unsigned;
  logic          lat_a0;
  logic [CW-1:0] wait_cnt;

  logic          req_bad;
  logic [1:0]    enc_wlen;
  logic [31:0]   enc_wdata;
  logic [7:0]    byte_sel;
  logic [31:0]   load_val;

  // A new request is only taken while idle and while the responder shows its
  // idle level, so a transaction abandoned by reset or timeout drains first.
  assign req_ready = (state == IDLE) && bus_ready;

  // Request decode: alignment check and the bus encoding of the access.
  always_comb begin
    req_bad   = (req_size == 2'b11) || ((req_size != 2'b00) && req_addr[0]);
    enc_wlen  = 2'b00;
    enc_wdata = 32'h0;
    if (req_we) begin
      case (req_size)
        2'b00:   begin enc_wlen = 2'b01; enc_wdata = {24'h0, req_wdata[7:0]};  end
        2'b01:   begin enc_wlen = 2'b10; enc_wdata = {16'h0, req_wdata[15:0]}; end
        default: begin enc_wlen = 2'b11; enc_wdata = req_wdata;                end
      endcase
    end
  end

  // Load extraction from the word on the bus; the responder has already moved
  // the addressed halfword into the low 16 bits, so only the byte lane varies.
  always_comb begin
    byte_sel = lat_a0 ? bus_rdata[15:8] : bus_rdata[7:0];
    case (lat_size)
      2'b00:   load_val = {{24{~lat_unsigned & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~lat_unsigned & bus_rdata[15]}}, bus_rdata[15:0]};
      default: load_val = bus_rdata;
    endcase
  end

  // Transaction sequencer. The bus fields change only on accept, so they stay
  // stable from the strobe until the response has been delivered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_a0       <= 1'b0;
      wait_cnt     <= '0;
      bus_address  <= 32'h0;
      bus_wdata    <= 32'h0;
      bus_wlen     <= 2'b00;
      bus_en_n     <= 1'b1;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_a0       <= req_addr[0];
            bus_address  <= req_addr;
            bus_wdata    <= enc_wdata;
            bus_wlen     <= enc_wlen;
            if (req_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state    <= ISSUE;
              bus_en_n <= 1'b0;
              wait_cnt <= '0;
            end
          end
        end
        ISSUE: begin
          bus_en_n <= 1'b1;
          state    <= WAIT_LO;
        end
        WAIT_LO: begin
          // bus_ready high here is the responder's idle level, not completion.
          wait_cnt <= wait_cnt + CW'(1);
          if (wait_cnt == WAIT_LAST) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0;
          end else if (!bus_ready) begin
            state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (bus_ready) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= lat_we ? 32'h0 : load_val;
          end else if (wait_cnt == WAIT_LAST) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
